// File: rtl/mux_result_uart_tx.sv
// rtl/mux_result_uart_tx.sv - buffers mux result bytes in a small FIFO and sends each as a UART frame
// Frame: start(0), 8 data bits LSB-first, stop(1); each bit lasts CLKS_PER_BIT clocks.
module mux_result_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX   = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  state_t        r_state;
  state_t        w_state_next;
  logic [BW-1:0] r_baud;
  logic [BW-1:0] w_baud_next;
  logic [2:0]    r_bit_idx;
  logic [2:0]    w_bit_idx_next;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_next;
  logic          r_tx;
  logic          w_tx_next;
  logic          w_push;
  logic          w_pop;
  logic          w_baud_done;
  logic          w_have_data;

  assign in_ready    = (r_level != LEVEL_FULL);
  assign w_push      = in_valid && in_ready;
  assign w_baud_done = (r_baud == BAUD_MAX);
  assign w_have_data = (r_level != '0);
  assign tx          = r_tx;
  assign level       = r_level;
  assign busy        = (r_state != IDLE) || w_have_data;

  // Next-state logic also computes the next tx level so tx can be registered.
  always_comb begin
    w_state_next   = r_state;
    w_baud_next    = r_baud + 1'b1;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_tx_next      = r_tx;
    w_pop          = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_next = '0;
        w_tx_next   = 1'b1;
        if (w_have_data) begin
          w_pop          = 1'b1;
          w_shift_next   = r_mem[r_rd_ptr];
          w_bit_idx_next = '0;
          w_state_next   = START;
          w_tx_next      = 1'b0;
        end
      end
      START: begin
        if (w_baud_done) begin
          w_baud_next    = '0;
          w_bit_idx_next = '0;
          w_state_next   = DATA;
          w_tx_next      = r_shift[0];
        end
      end
      DATA: begin
        if (w_baud_done) begin
          w_baud_next = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_next = STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_shift_next   = {1'b0, r_shift[7:1]};
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_tx_next      = r_shift[1];
          end
        end
      end
      STOP: begin
        if (w_baud_done) begin
          w_baud_next = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (w_have_data) begin
            w_pop          = 1'b1;
            w_shift_next   = r_mem[r_rd_ptr];
            w_bit_idx_next = '0;
            w_state_next   = START;
            w_tx_next      = 1'b0;
          end else begin
            w_state_next = IDLE;
            w_tx_next    = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_baud_next  = '0;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_mux_result_uart_tx.sv
// tb/tb_mux_result_uart_tx.sv - directed self-checking bench for mux_result_uart_tx
// Inputs change 1ns after rising edges; outputs are sampled on falling edges.
module tb_mux_result_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [1:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  mux_result_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  // Expected line level for bit slot 0..9 of a frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", tx); end
    n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_idle_guard();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n_checks++; if (tx !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL idle_guard cycle %0d got tx=%b busy=%b want tx=1 busy=0", c, tx, busy);
      end
    end
  endtask

  task automatic test_single_byte();
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hA5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (tx !== 1'b1 || level !== 2'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_after_push got tx=%b level=%0d busy=%b want 1/1/1", tx, level, busy);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n_checks++; if (tx !== frame_bit(8'hA5, k / 4)) begin
        n_fail++; $display("FAIL single_tx cycle %0d got %b want %b", k, tx, frame_bit(8'hA5, k / 4));
      end
    end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_last_stop got %b want 1", busy); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || tx !== 1'b1 || level !== 2'd0) begin
      n_fail++; $display("FAIL single_done got busy=%b tx=%b level=%0d want 0/1/0", busy, tx, level);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bb [3];
    bb[0] = 8'h00; bb[1] = 8'hFF; bb[2] = 8'h3C;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = bb[0];
    fork
      begin
        @(posedge clk); #1 in_data = bb[1];
        @(posedge clk); #1 in_data = bb[2];
        @(posedge clk); #1 in_valid = 1'b0;
      end
      begin
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 120; k++) begin
          @(negedge clk);
          n_checks++; if (tx !== frame_bit(bb[k / 40], (k % 40) / 4)) begin
            n_fail++; $display("FAIL b2b_tx cycle %0d got %b want %b", k, tx, frame_bit(bb[k / 40], (k % 40) / 4));
          end
        end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || tx !== 1'b1) begin
          n_fail++; $display("FAIL b2b_done got busy=%b tx=%b want 0/1", busy, tx);
        end
      end
    join
  endtask

  task automatic test_backpressure();
    logic [7:0] bp [4];
    int         acc [4];
    logic       rdy_hist [64];
    logic [1:0] lvl_hist [64];
    bp[0] = 8'h11; bp[1] = 8'h96; bp[2] = 8'hC3; bp[3] = 8'h7E;
    acc[0] = 0; acc[1] = -1; acc[2] = -1; acc[3] = -1;
    for (int i = 0; i < 64; i++) begin rdy_hist[i] = 1'bx; lvl_hist[i] = 2'bxx; end
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = bp[0];
    fork
      begin
        int  edge_n;
        logic rdy;
        @(posedge clk);
        edge_n = 0;
        for (int i = 1; i < 4; i++) begin
          #1 in_data = bp[i];
          for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            rdy = in_ready;
            if (edge_n < 64) begin rdy_hist[edge_n] = in_ready; lvl_hist[edge_n] = level; end
            @(posedge clk);
            edge_n++;
            if (rdy) begin acc[i] = edge_n; break; end
          end
        end
        #1 in_valid = 1'b0;
      end
      begin
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 160; k++) begin
          @(negedge clk);
          n_checks++; if (tx !== frame_bit(bp[k / 40], (k % 40) / 4)) begin
            n_fail++; $display("FAIL bp_tx cycle %0d got %b want %b", k, tx, frame_bit(bp[k / 40], (k % 40) / 4));
          end
        end
      end
    join
    n_checks++; if (acc[1] !== 1) begin n_fail++; $display("FAIL bp_accept1 edge got %0d want 1", acc[1]); end
    n_checks++; if (acc[2] !== 2) begin n_fail++; $display("FAIL bp_accept2 edge got %0d want 2", acc[2]); end
    n_checks++; if (acc[3] !== 42) begin n_fail++; $display("FAIL bp_accept3 edge got %0d want 42", acc[3]); end
    n_checks++; if (rdy_hist[2] !== 1'b0 || lvl_hist[2] !== 2'd2) begin
      n_fail++; $display("FAIL bp_full_early got ready=%b level=%0d want 0/2", rdy_hist[2], lvl_hist[2]);
    end
    n_checks++; if (rdy_hist[40] !== 1'b0 || lvl_hist[40] !== 2'd2) begin
      n_fail++; $display("FAIL bp_full_last_stop got ready=%b level=%0d want 0/2", rdy_hist[40], lvl_hist[40]);
    end
    n_checks++; if (rdy_hist[41] !== 1'b1 || lvl_hist[41] !== 2'd1) begin
      n_fail++; $display("FAIL bp_after_pop got ready=%b level=%0d want 1/1", rdy_hist[41], lvl_hist[41]);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] sb [3];
    sb[0] = 8'h81; sb[1] = 8'h5A; sb[2] = 8'hE7;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = sb[0];
    fork
      begin
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 begin in_valid = 1'b1; in_data = sb[1]; end
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (38) @(posedge clk);
        #1 begin in_valid = 1'b1; in_data = sb[2]; end
        @(negedge clk);
        n_checks++; if (level !== 2'd1 || in_ready !== 1'b1) begin
          n_fail++; $display("FAIL simul_before got level=%0d ready=%b want 1/1", level, in_ready);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (level !== 2'd1) begin
          n_fail++; $display("FAIL simul_level got %0d want 1", level);
        end
      end
      begin
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 120; k++) begin
          @(negedge clk);
          n_checks++; if (tx !== frame_bit(sb[k / 40], (k % 40) / 4)) begin
            n_fail++; $display("FAIL simul_tx cycle %0d got %b want %b", k, tx, frame_bit(sb[k / 40], (k % 40) / 4));
          end
        end
      end
    join
  endtask

  task automatic test_reset_mid_frame();
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h00;
    @(posedge clk);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    n_checks++; if (tx !== 1'b0 || level !== 2'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL midframe_pre got tx=%b level=%0d busy=%b want 0/1/1", tx, level, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (tx !== 1'b1 || level !== 2'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midframe_async got tx=%b level=%0d ready=%b busy=%b want 1/0/1/0", tx, level, in_ready, busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      n_checks++; if (tx !== 1'b1 || busy !== 1'b0 || level !== 2'd0) begin
        n_fail++; $display("FAIL midframe_after cycle %0d got tx=%b busy=%b level=%0d want 1/0/0", c, tx, busy, level);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_guard();
    test_single_byte();
    repeat (3) @(posedge clk);
    test_back_to_back();
    repeat (3) @(posedge clk);
    test_backpressure();
    repeat (3) @(posedge clk);
    test_simultaneous();
    repeat (3) @(posedge clk);
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
